cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder; successor to the fixed 16-bit ripple-of-CLA-groups adder.
- Splits a WIDTH-bit add into STAGES registered slices. Each slice is built from GROUP-bit lookahead groups with group-level lookahead inside the slice.
- Carry is registered between slices, so the block sustains one add per cycle at high clock rate.
- Valid/ready handshake on both sides; feeds the ALU datapath and the MAC accumulator.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of STAGES*GROUP.
- STAGES, 4, pipeline depth = number of slices; SLICE = WIDTH/STAGES bits per stage.
- GROUP, 4, bits per lookahead group inside a slice.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  A+B+cin.
- cout  output  1  unsigned carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all stage valid bits, out_valid, sum, cout, ovf and all internal operand/carry/partial-sum registers clear to 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: every in-flight transaction is discarded; no result for them ever appears.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, purely combinational, with no dependence on in_valid.
- Stall: on a stall every stage holds, including valid bits and data. Bubbles are not squeezed out.
- Input transfer: occurs when in_valid && in_ready. On transfer, stage 0 captures a, b and cin. It adds slice 0 (bits SLICE-1:0) and registers the partial sum, the slice carry-out and the untouched upper operand bits.
- Stage k (1..STAGES-1):
  - Adds bits [(k+1)*SLICE-1 : k*SLICE] using the registered carry from stage k-1.
  - Lower sum bits pass through delay registers (skew alignment).
  - Upper operand bits still to be added continue forward.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls. Throughput is 1 result/cycle when out_ready is held high.
- Output transfer: occurs when out_valid && out_ready. sum, cout and ovf are stable while out_valid && !out_ready.
- Simultaneous events: output transfer and input transfer in the same cycle are legal; the pipe shifts normally.
- Slice internals:
  - Per bit: g=a&b, p=a^b.
  - Per group: GROUP-bit lookahead giving group G/P.
  - Across groups within a slice: lookahead carry on group G/P.
  - No ripple longer than one group.
- Arithmetic is modulo 2^WIDTH. cout = bit WIDTH of the full sum. ovf is computed in the last stage.
- Parameter check: an elaboration-time assertion fires if WIDTH % (STAGES*GROUP) != 0 or STAGES < 1.

Optional Feature:
- Macro: CLA_PIPE_SUB_EN.
- When defined:
  - Extra port: sub  input  1, sampled with a.
  - When sub=1, stage 0 uses ~b and a forced carry-in of 1, ignoring cin, giving A-B.
  - cout is then the no-borrow flag (1 means A>=B unsigned).
  - ovf remains the signed-overflow flag for the subtract.
- When undefined: no sub port, and the datapath is add only.

Decomposition:
- Package cla_pkg:
  - Default width/stage/group constants.
  - Typedef for the per-stage pipeline record {valid, a_rem, b_rem, sum_part, carry}.
  - Function computing group G/P from GROUP-bit g/p vectors.
- Sub-module cla_slice: combinational, parameter SLICE and GROUP; inputs a, b, cin; outputs sum, cout, and carry-into-MSB (used for ovf).
- The top instantiates STAGES cla_slice instances in a generate loop and owns all registers and the handshake.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> out_valid, sum, cout, ovf all 0; no result emitted for that input after rst drops.
- Full carry chain (WIDTH=32, STAGES=4): a=0xFFFFFFFF, b=0x00000001, cin=0 -> after exactly 4 cycles sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Streaming: 64 back-to-back random pairs with out_ready=1 -> one result/cycle, in order, all matching a+b+cin.
- Backpressure: out_ready=0 for 3 cycles while the pipe is full -> in_ready=0, sum held constant; resume -> no loss or duplication. Also rst asserted mid-stream -> pipe empty next cycle.
- With CLA_PIPE_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, pipeline record and group lookahead helper for cla_pipe_adder.
// The group helper takes MAX_GROUP-bit vectors; callers pad unused g with 0, p with 1.
package cla_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_GROUP  = 4;
    localparam int MAX_GROUP  = 8;

    // Per-stage record at the default width; the top declares a WIDTH-sized twin.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
        logic [DEF_WIDTH-1:0] sum_part;
        logic                 carry;
    } stage_rec_t;

    // Returns {G, P} for one lookahead group.
    function automatic logic [1:0] grp_gp(
        input logic [MAX_GROUP-1:0] g,
        input logic [MAX_GROUP-1:0] p
    );
        logic gg;
        logic gp;
        gg = 1'b0;
        gp = 1'b1;
        for (int i = 0; i < MAX_GROUP; i++) begin
            gg = g[i] | (p[i] & gg);
            gp = gp & p[i];
        end
        return {gg, gp};
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The sub signal exists only when CLA_PIPE_SUB_EN is defined.
interface cla_pipe_adder_if #(
    parameter int WIDTH = cla_pkg::DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CLA_PIPE_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from GROUP-bit groups.
// Group carries are two-level lookahead; ripple never spans more than one group.
module cla_slice
    import cla_pkg::*;
#(
    parameter int SLICE = 8,
    parameter int GROUP = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    localparam int NG = SLICE / GROUP;

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic [MAX_GROUP-1:0] gv;
        logic [MAX_GROUP-1:0] pv;
        logic [1:0]           gp;
        logic                 acc;
        logic                 cj;
        logic                 rc;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < NG; j++) begin
            gv = '0;
            pv = '1;
            gv[GROUP-1:0] = g[j*GROUP +: GROUP];
            pv[GROUP-1:0] = p[j*GROUP +: GROUP];
            gp = grp_gp(gv, pv);
            grp_g[j] = gp[1];
            grp_p[j] = gp[0];
        end
        // Each group carry is a flat sum of products over lower groups and cin.
        for (int j = 0; j <= NG; j++) begin
            acc = 1'b1;
            cj  = 1'b0;
            for (int i = j - 1; i >= 0; i--) begin
                cj  = cj | (grp_g[i] & acc);
                acc = acc & grp_p[i];
            end
            grp_c[j] = cj | (cin & acc);
        end
        for (int j = 0; j < NG; j++) begin
            rc = grp_c[j];
            for (int i = 0; i < GROUP; i++) begin
                c[j*GROUP+i] = rc;
                rc = g[j*GROUP+i] | (p[j*GROUP+i] & rc);
            end
        end
    end

    assign sum   = p ^ c;
    assign cout  = grp_c[NG];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: STAGES registered slices, one add per cycle.
// Define CLA_PIPE_SUB_EN to add the sub port (A-B with forced carry-in).
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int GROUP  = DEF_GROUP
) (
    input logic             clk,
    input logic             rst,
    cla_pipe_adder_if.slave io
);

    localparam int STG   = (STAGES < 1) ? 1 : STAGES;
    localparam int SLICE = WIDTH / STG;
    localparam int LAST  = STG - 1;
    localparam int NR    = (STG > 1) ? STG - 1 : 1;

    if (STAGES < 1 || (WIDTH % (STG * GROUP)) != 0 || GROUP > MAX_GROUP)
    begin : g_bad_cfg
        $error("cla_pipe_adder: illegal WIDTH/STAGES/GROUP combination");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_part;
        logic             carry;
    } stage_t;

    stage_t           st_q [NR];
    stage_t           st_d [NR];
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic [WIDTH-1:0] src_a [STG];
    logic [WIDTH-1:0] src_b [STG];
    logic [WIDTH-1:0] src_s [STG];
    logic             src_c [STG];
    logic             src_v [STG];
    logic [SLICE-1:0] sl_sum [STG];
    logic             sl_co [STG];
    logic             sl_cm [STG];

`ifdef CLA_PIPE_SUB_EN
    assign b_in = io.sub ? ~io.b : io.b;
    assign c_in = io.sub | io.cin;
`else
    assign b_in = io.b;
    assign c_in = io.cin;
`endif

    // Whole pipe moves together; bubbles are kept, not squeezed out.
    assign adv         = !out_valid_q || io.out_ready;
    assign io.in_ready = adv;

    for (genvar k = 0; k < STG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_a[k] = io.a;
            assign src_b[k] = b_in;
            assign src_c[k] = c_in;
            assign src_s[k] = '0;
            assign src_v[k] = io.in_valid;
        end else begin : g_body
            assign src_a[k] = st_q[k-1].a_rem;
            assign src_b[k] = st_q[k-1].b_rem;
            assign src_c[k] = st_q[k-1].carry;
            assign src_s[k] = st_q[k-1].sum_part;
            assign src_v[k] = st_q[k-1].valid;
        end

        cla_slice #(
            .SLICE (SLICE),
            .GROUP (GROUP)
        ) u_slice (
            .a     (src_a[k][SLICE-1:0]),
            .b     (src_b[k][SLICE-1:0]),
            .cin   (src_c[k]),
            .sum   (sl_sum[k]),
            .cout  (sl_co[k]),
            .c_msb (sl_cm[k])
        );
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            st_d[i] = st_q[i];
        end
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (adv) begin
            // Operands shift down one slice; new sum bits enter at the top.
            for (int i = 0; i < LAST; i++) begin
                st_d[i].valid    = src_v[i];
                st_d[i].a_rem    = src_a[i] >> SLICE;
                st_d[i].b_rem    = src_b[i] >> SLICE;
                st_d[i].sum_part = WIDTH'({sl_sum[i], src_s[i]} >> SLICE);
                st_d[i].carry    = sl_co[i];
            end
            out_valid_d = src_v[LAST];
            sum_d       = WIDTH'({sl_sum[LAST], src_s[LAST]} >> SLICE);
            cout_d      = sl_co[LAST];
            ovf_d       = sl_co[LAST] ^ sl_cm[LAST];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                st_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                st_q[i] <= st_d[i];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: expected results queued at input transfer,
// compared at output transfer, with latency, stall-hold and reset-flush checks.
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [31:0]  t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH  (W),
        .STAGES (S),
        .GROUP  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   lat_on = 1'b1;
    logic sub_v  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb_);
        exp_t         e;
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   r;
        bb = sb_ ? ~b : b;
        c  = sb_ ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.t    = cyc;
        return e;
    endfunction

    // Inputs are set at the negedge; transfers are evaluated 1 ns later.
    task automatic tick();
        exp_t e;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sum", bus.sum, e.sum);
                    check("cout", bus.cout, e.cout);
                    check("ovf", bus.ovf, e.ovf);
                    if (lat_on) check("latency", cyc - int'(e.t), S);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.a, bus.b, bus.cin, sub_v));
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        tick();
    endtask

    task automatic drain();
        int k = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [W-1:0] hold;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 32'h1234_5678;
        bus.b         = 32'h0000_0001;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b1;
`ifdef CLA_PIPE_SUB_EN
        bus.sub       = 1'b0;
`endif
        @(negedge clk);
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        repeat (S + 2) tick();
        check("rst_no_out", bus.out_valid, 0);

        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drive(32'h0000_0000, 32'h0000_0000, 1'b0);
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        drain();

        for (int i = 0; i < 64; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain();

        lat_on = 1'b0;
        for (int i = 0; i < S; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = $urandom;
        bus.b         = $urandom;
        #1;
        check("bp_full", bus.out_valid, 1);
        hold = bus.sum;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_hold", bus.sum, hold);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < S; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain();

        lat_on = 1'b1;
        for (int i = 0; i < 3; i++)
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_flush", bus.out_valid, 0);
        repeat (S + 2) tick();
        check("rst_flush_sb", sb.size(), 0);

`ifdef CLA_PIPE_SUB_EN
        sub_v   = 1'b1;
        bus.sub = 1'b1;
        drive(32'd5, 32'd7, 1'b0);
        drive(32'd7, 32'd5, 1'b0);
        drive(32'h8000_0000, 32'd1, 1'b0);
        drain();
        sub_v   = 1'b0;
        bus.sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
